// File: rtl/decode_stage.sv
// decode_stage: RV32I integer ALU instruction decoder (OP and OP-IMM only)
// with one registered pipeline slot between fetch and execute.
//
// Ports:
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   flush                   kills the slot and any instruction offered this cycle
//   in_valid / in_ready     fetch-side handshake
//   in_instr, in_pc         raw instruction word and its address
//   out_valid / out_ready   execute-side handshake
//   out_pc                  registered in_pc
//   out_alu_op              ALU operation (decode_stage_pkg::alu_op_t)
//   out_is_imm              second ALU operand is out_imm_i
//   out_imm_i               sign-extended instr[31:20]
//   out_rs1, out_rs2, out_rd register addresses (rs2 forced to 0 for OP-IMM)
//   out_rd_we               write rd (never for x0 or illegal instructions)
//   out_illegal             instruction could not be decoded
//
// Build option:
//   DECODE_ILLEGAL_EN  when defined, illegal instructions pass through flagged
//                      by out_illegal so that execute can trap. When undefined,
//                      they are replaced by NOP_INSTR and out_illegal is tied 0.

package decode_stage_pkg;
    typedef enum logic [3:0] {
        i_ADD  = 4'd0,
        i_SUB  = 4'd1,
        i_SLL  = 4'd2,
        i_SLT  = 4'd3,
        i_SLTU = 4'd4,
        i_XOR  = 4'd5,
        i_SRL  = 4'd6,
        i_SRA  = 4'd7,
        i_OR   = 4'd8,
        i_AND  = 4'd9
    } alu_op_t;
endpackage

module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output alu_op_t         out_alu_op,
    output logic            out_is_imm,
    output logic [XLEN-1:0] out_imm_i,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            legal;
    alu_op_t         legal_op;

    logic [XLEN-1:0] dec_instr;
    alu_op_t         dec_alu_op;
    logic            dec_is_imm;
    logic [XLEN-1:0] dec_imm_i;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [4:0]      dec_rd;
    logic            dec_rd_we;
    logic            dec_illegal;

    logic            accept;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // Legality and ALU operation. For OP-IMM the funct7 position holds the
    // upper immediate bits, which only matter for the shift encodings.
    always_comb begin
        legal    = 1'b0;
        legal_op = i_ADD;
        if (opcode == OPC_OP) begin
            if (funct7 == F7_ZERO) begin
                legal = 1'b1;
                case (funct3)
                    3'b000:  legal_op = i_ADD;
                    3'b001:  legal_op = i_SLL;
                    3'b010:  legal_op = i_SLT;
                    3'b011:  legal_op = i_SLTU;
                    3'b100:  legal_op = i_XOR;
                    3'b101:  legal_op = i_SRL;
                    3'b110:  legal_op = i_OR;
                    default: legal_op = i_AND;
                endcase
            end else if (funct7 == F7_ALT) begin
                if (funct3 == 3'b000) begin
                    legal    = 1'b1;
                    legal_op = i_SUB;
                end else if (funct3 == 3'b101) begin
                    legal    = 1'b1;
                    legal_op = i_SRA;
                end
            end
        end else if (opcode == OPC_OP_IMM) begin
            case (funct3)
                3'b000: begin legal = 1'b1; legal_op = i_ADD;  end
                3'b010: begin legal = 1'b1; legal_op = i_SLT;  end
                3'b011: begin legal = 1'b1; legal_op = i_SLTU; end
                3'b100: begin legal = 1'b1; legal_op = i_XOR;  end
                3'b110: begin legal = 1'b1; legal_op = i_OR;   end
                3'b111: begin legal = 1'b1; legal_op = i_AND;  end
                3'b001: begin
                    legal    = (funct7 == F7_ZERO);
                    legal_op = i_SLL;
                end
                default: begin
                    if (funct7 == F7_ZERO) begin
                        legal    = 1'b1;
                        legal_op = i_SRL;
                    end else if (funct7 == F7_ALT) begin
                        legal    = 1'b1;
                        legal_op = i_SRA;
                    end
                end
            endcase
        end
    end

`ifdef DECODE_ILLEGAL_EN
    // Illegal words keep their raw fields so the trap handler sees them.
    assign dec_instr   = in_instr;
    assign dec_illegal = !legal;
`else
    // Illegal words are swapped for the NOP before field extraction, so every
    // field matches what the NOP itself would decode to.
    assign dec_instr   = legal ? in_instr : NOP_INSTR;
    assign dec_illegal = 1'b0;
`endif

    assign dec_alu_op = legal ? legal_op : i_ADD;
    assign dec_is_imm = (dec_instr[6:0] == OPC_OP_IMM);
    assign dec_imm_i  = {{(XLEN-12){dec_instr[31]}}, dec_instr[31:20]};
    assign dec_rs1    = dec_instr[19:15];
    assign dec_rs2    = dec_is_imm ? 5'd0 : dec_instr[24:20];
    assign dec_rd     = dec_instr[11:7];
    assign dec_rd_we  = legal && (dec_rd != 5'd0);

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Slot occupancy; flush overrides both a new accept and a pending hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload only changes on accept, keeping it stable during stalls and
    // quiet during bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pc      <= '0;
            out_alu_op  <= i_ADD;
            out_is_imm  <= 1'b0;
            out_imm_i   <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_pc      <= in_pc;
            out_alu_op  <= dec_alu_op;
            out_is_imm  <= dec_is_imm;
            out_imm_i   <= dec_imm_i;
            out_rs1     <= dec_rs1;
            out_rs2     <= dec_rs2;
            out_rd      <= dec_rd;
            out_rd_we   <= dec_rd_we;
            out_illegal <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage. Stimulus pushes the
// reference decode of every accepted instruction into a queue; a monitor on
// the falling edge compares the DUT slot against the queue head.

module tb_decode_stage;
    import decode_stage_pkg::*;

    typedef struct {
        logic [31:0] pc;
        alu_op_t     op;
        logic        is_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    alu_op_t     out_alu_op;
    logic        out_is_imm;
    logic [31:0] out_imm_i;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_illegal;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    decode_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_alu_op (out_alu_op),
        .out_is_imm (out_is_imm),
        .out_imm_i  (out_imm_i),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_rd     (out_rd),
        .out_rd_we  (out_rd_we),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Reference decode written straight from the instruction set tables.
    function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] pc);
        alu_op_t r_tab[8];
        alu_op_t i_tab[8];
        exp_t    e;
        logic    legal;
        alu_op_t op;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        r_tab = '{i_ADD, i_SLL, i_SLT, i_SLTU, i_XOR, i_SRL, i_OR, i_AND};
        i_tab = '{i_ADD, i_SLL, i_SLT, i_SLTU, i_XOR, i_SRL, i_OR, i_AND};
        opc   = instr[6:0];
        f3    = instr[14:12];
        f7    = instr[31:25];
        legal = 1'b0;
        op    = i_ADD;
        if (opc == 7'h33) begin
            if (f7 == 7'h00) begin
                legal = 1'b1;
                op    = r_tab[f3];
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                legal = 1'b1;
                op    = i_SUB;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                legal = 1'b1;
                op    = i_SRA;
            end
        end else if (opc == 7'h13) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                if (f7 == 7'h00) begin
                    legal = 1'b1;
                    op    = i_tab[f3];
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    legal = 1'b1;
                    op    = i_SRA;
                end
            end else begin
                legal = 1'b1;
                op    = i_tab[f3];
            end
        end
        e.pc = pc;
        if (legal) begin
            e.op     = op;
            e.is_imm = (opc == 7'h13);
            e.imm    = 32'(signed'(instr[31:20]));
            e.rs1    = instr[19:15];
            e.rs2    = e.is_imm ? 5'd0 : instr[24:20];
            e.rd     = instr[11:7];
            e.we     = (instr[11:7] != 5'd0);
            e.ill    = 1'b0;
        end else begin
`ifdef DECODE_ILLEGAL_EN
            e.op     = i_ADD;
            e.is_imm = (opc == 7'h13);
            e.imm    = 32'(signed'(instr[31:20]));
            e.rs1    = instr[19:15];
            e.rs2    = e.is_imm ? 5'd0 : instr[24:20];
            e.rd     = instr[11:7];
            e.we     = 1'b0;
            e.ill    = 1'b1;
`else
            // ADDI x0, x0, 0
            e.op     = i_ADD;
            e.is_imm = 1'b1;
            e.imm    = 32'd0;
            e.rs1    = 5'd0;
            e.rs2    = 5'd0;
            e.rd     = 5'd0;
            e.we     = 1'b0;
            e.ill    = 1'b0;
`endif
        end
        return e;
    endfunction

    function automatic logic [127:0] pack_exp(input exp_t e);
        return {42'd0, e.pc, 4'(e.op), e.is_imm, e.imm, e.rs1, e.rs2, e.rd, e.we, e.ill};
    endfunction

    function automatic logic [127:0] pack_dut();
        return {42'd0, out_pc, 4'(out_alu_op), out_is_imm, out_imm_i,
                out_rs1, out_rs2, out_rd, out_rd_we, out_illegal};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [6:0] f7;
        logic [6:0] opc;
        int         kind;
        kind = int'($urandom_range(0, 9));
        case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        if (kind <= 3)      opc = 7'h33;
        else if (kind <= 7) opc = 7'h13;
        else if (kind == 8) return $urandom;
        else                return 32'd0;
        return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the slot against the scoreboard head, then advances
    // the model by what the coming rising edge will do.
    initial begin
        logic model_ready;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
            end else begin
                model_ready = (sb.size() == 0) || out_ready;
                checkOutput("out_valid", 128'(out_valid), 128'(sb.size() != 0));
                checkOutput("in_ready", 128'(in_ready), 128'(model_ready));
                if (out_valid && sb.size() != 0)
                    checkOutput("payload", pack_dut(), pack_exp(sb[0]));
                if (flush) begin
                    sb.delete();
                end else begin
                    if (sb.size() != 0 && out_ready)
                        void'(sb.pop_front());
                    if (in_valid && model_ready)
                        sb.push_back(ref_decode(in_instr, in_pc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] directed[8];
        logic [31:0] pc;
        directed = '{32'h002081B3, 32'h407302B3, 32'hFFF00093, 32'h40315113,
                     32'h00005013, 32'h00000000, 32'h400010B3, 32'h00B57633};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_pc     = 32'd0;
        out_ready = 1'b0;
        pc        = 32'h0000_1000;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", 128'(out_valid), 128'd0);
        checkOutput("reset_payload", pack_dut(), 128'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;

        $display("[TB] directed back-to-back stream");
        foreach (directed[i]) begin
            applyStimulus(1'b1, directed[i], pc, 1'b1, 1'b0);
            pc += 4;
        end
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        $display("[TB] five-cycle stall");
        applyStimulus(1'b1, 32'h002081B3, pc, 1'b1, 1'b0);
        pc += 4;
        repeat (5) applyStimulus(1'b1, 32'h407302B3, pc, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h407302B3, pc, 1'b1, 1'b0);
        pc += 4;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        $display("[TB] flush with slot full");
        applyStimulus(1'b1, 32'hFFF00093, pc, 1'b0, 1'b0);
        pc += 4;
        applyStimulus(1'b1, 32'h40315113, pc, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), gen_instr(), $urandom,
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
        end
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        $display("[TB] reset during stall");
        applyStimulus(1'b1, 32'h002081B3, pc, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", 128'(out_valid), 128'd0);
        checkOutput("midreset_payload", pack_dut(), 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h00B57633, pc, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("drained_valid", 128'(out_valid), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
